ball_move: RTL and testbench

- Ball-motion responder for the 16x16 pong field; the consuming end of the plate/ball-position interface.
- Takes the paddle position produced by the candidate finder, steps the ball one cell every TICK_DIV cycles, and bounces it off the top/bottom walls and the paddle.
- Publishes the ball position in the same packed {x,y} format the candidate finder consumes.
- Flags hits and misses to the score and serve logic.

---
 rtl/ball_move.sv | 150 +++++++++++++++
 tb/tb_ball_move.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ball_move.sv
// Ball-motion responder for the pong field: steps the ball every TICK_DIV
// cycles, bounces it off the top/bottom walls and the paddle, and flags
// hits and misses to the score/serve logic.
module ball_move #(
    parameter int WIDTH        = 16,
    parameter int BIT_OF_WIDTH = 4,
    parameter int TICK_DIV     = 4,
    parameter int PLATE_LEN    = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [BIT_OF_WIDTH*2-1:0]   plate,
    output logic [BIT_OF_WIDTH*2-1:0]   pos,
    output logic [1:0]                  dir,
    output logic                        busy,
    output logic                        hit,
    output logic                        miss,
    output logic [7:0]                  hit_count
);

    localparam int B   = BIT_OF_WIDTH;
    localparam int BW1 = BIT_OF_WIDTH + 1;
    localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [B-1:0]   MAX_C     = B'(WIDTH - 1);
    localparam logic [B-1:0]   CENTER    = B'(WIDTH / 2);
    localparam logic [BW1-1:0] PL_SPAN   = BW1'(PLATE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        MOVE,
        MISS
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  tick_q;
    logic           toggle_q;

    logic [B-1:0]   x, y, x_plate, y_plate;
    logic           dx, dy;
    logic [BW1-1:0] nx;
    logic           paddle, edge_x, edge_y, step;

    logic [B-1:0]   x_step, y_step;
    logic [1:0]     dir_step;
    logic           hit_step, miss_step;

    assign x       = pos[2*B-1:B];
    assign y       = pos[B-1:0];
    assign dx      = dir[1];
    assign dy      = dir[0];
    assign x_plate = plate[2*B-1:B];
    assign y_plate = plate[B-1:0];

    // nx is one bit wider so stepping past either edge never aliases onto
    // a paddle column; the paddle row range is likewise unclipped.
    assign nx     = dx ? ({1'b0, x} + BW1'(1)) : ({1'b0, x} - BW1'(1));
    assign paddle = (nx == {1'b0, x_plate}) &&
                    ({1'b0, y} >= {1'b0, y_plate}) &&
                    ({1'b0, y} <= ({1'b0, y_plate} + PL_SPAN));
    assign edge_x = dx ? (x == MAX_C) : (x == '0);
    assign edge_y = dy ? (y == MAX_C) : (y == '0);
    assign step   = (state_q == MOVE) && (tick_q == TICK_LAST);
    assign busy   = (state_q == SERVE) || (state_q == MOVE);

    // Candidate position/direction for a step, x and y from pre-step values.
    always_comb begin
        x_step    = x;
        y_step    = y;
        dir_step  = dir;
        hit_step  = 1'b0;
        miss_step = 1'b0;
        if (paddle) begin
            hit_step    = 1'b1;
            dir_step[1] = ~dx;
        end else if (edge_x) begin
            miss_step = 1'b1;
        end else begin
            x_step = nx[B-1:0];
        end
        if (!miss_step) begin
            if (edge_y) begin
                dir_step[0] = ~dy;
            end else begin
                y_step = dy ? (y + B'(1)) : (y - B'(1));
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SERVE;
            SERVE:   state_d = MOVE;
            MOVE:    if (step && miss_step) state_d = MISS;
            MISS:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Ball datapath, tick counter, serve toggle and hit/miss pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos       <= {CENTER, CENTER};
            dir       <= 2'b11;
            toggle_q  <= 1'b0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            hit_count <= 8'd0;
            tick_q    <= '0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            case (state_q)
                SERVE: begin
                    pos       <= {CENTER, CENTER};
                    dir       <= {~toggle_q, ~toggle_q};
                    toggle_q  <= ~toggle_q;
                    hit_count <= 8'd0;
                    tick_q    <= '0;
                end
                MOVE: begin
                    if (step) begin
                        tick_q <= '0;
                        pos    <= {x_step, y_step};
                        dir    <= dir_step;
                        hit    <= hit_step;
                        miss   <= miss_step;
                        if (hit_step && (hit_count != 8'hFF))
                            hit_count <= hit_count + 8'd1;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_move.sv
// Bench for ball_move: two instances (TICK_DIV 1 and 4) share stimulus and
// are compared every cycle against an integer-arithmetic model of the ball.
module tb_ball_move;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] plate;
    logic [7:0] pos1, pos4, hc1, hc4;
    logic [1:0] dir1, dir4;
    logic       busy1, busy4, hit1, hit4, miss1, miss4;

    int checks = 0;
    int errors = 0;

    // Model state per instance; mode 0 idle, 1 serve, 2 move, 3 miss.
    int td[2] = '{1, 4};
    int m_mode[2], m_x[2], m_y[2], m_dx[2], m_dy[2];
    int m_tog[2], m_cnt[2], m_hits[2], m_hit[2], m_miss[2];

    ball_move #(.WIDTH(16), .BIT_OF_WIDTH(4), .TICK_DIV(1), .PLATE_LEN(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .plate(plate), .pos(pos1),
        .dir(dir1), .busy(busy1), .hit(hit1), .miss(miss1), .hit_count(hc1));

    ball_move #(.WIDTH(16), .BIT_OF_WIDTH(4), .TICK_DIV(4), .PLATE_LEN(3)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .plate(plate), .pos(pos4),
        .dir(dir4), .busy(busy4), .hit(hit4), .miss(miss4), .hit_count(hc4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_x[i] = 8; m_y[i] = 8; m_dx[i] = 1; m_dy[i] = 1;
            m_tog[i] = 0; m_cnt[i] = 0; m_hits[i] = 0; m_hit[i] = 0; m_miss[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input logic [7:0] pl);
        int px, py, nx, ny;
        px = int'(pl[7:4]);
        py = int'(pl[3:0]);
        nx = m_x[i] + (m_dx[i] != 0 ? 1 : -1);
        ny = m_y[i] + (m_dy[i] != 0 ? 1 : -1);
        if (nx == px && m_y[i] >= py && m_y[i] <= py + 2) begin
            m_dx[i]   = 1 - m_dx[i];
            m_hit[i]  = 1;
            m_hits[i] = (m_hits[i] < 255) ? m_hits[i] + 1 : 255;
        end else if (nx < 0 || nx > 15) begin
            m_miss[i] = 1;
            m_mode[i] = 3;
        end else begin
            m_x[i] = nx;
        end
        if (m_miss[i] == 0) begin
            if (ny < 0 || ny > 15) m_dy[i] = 1 - m_dy[i];
            else                   m_y[i]  = ny;
        end
    endtask

    task automatic model_clock(input logic st, input logic [7:0] pl);
        for (int i = 0; i < 2; i++) begin
            m_hit[i]  = 0;
            m_miss[i] = 0;
            case (m_mode[i])
                0: if (st) m_mode[i] = 1;
                1: begin
                    m_x[i] = 8; m_y[i] = 8;
                    m_dx[i] = 1 - m_tog[i]; m_dy[i] = 1 - m_tog[i];
                    m_tog[i] = 1 - m_tog[i];
                    m_hits[i] = 0; m_cnt[i] = 0; m_mode[i] = 2;
                end
                2: begin
                    m_cnt[i]++;
                    if (m_cnt[i] == td[i]) begin
                        m_cnt[i] = 0;
                        model_step(i, pl);
                    end
                end
                default: m_mode[i] = 0;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("pos_td1",  int'(pos1), m_x[0] * 16 + m_y[0]);
        chk("dir_td1",  int'(dir1), m_dx[0] * 2 + m_dy[0]);
        chk("busy_td1", int'(busy1), int'(m_mode[0] == 1 || m_mode[0] == 2));
        chk("hit_td1",  int'(hit1), m_hit[0]);
        chk("miss_td1", int'(miss1), m_miss[0]);
        chk("hc_td1",   int'(hc1), m_hits[0]);
        chk("pos_td4",  int'(pos4), m_x[1] * 16 + m_y[1]);
        chk("dir_td4",  int'(dir4), m_dx[1] * 2 + m_dy[1]);
        chk("busy_td4", int'(busy4), int'(m_mode[1] == 1 || m_mode[1] == 2));
        chk("hit_td4",  int'(hit4), m_hit[1]);
        chk("miss_td4", int'(miss4), m_miss[1]);
        chk("hc_td4",   int'(hc4), m_hits[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else     model_clock(start, plate);
        @(negedge clk);
        compare_all();
    endtask

    task automatic serve();
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int n = 0; n < 400 && !done; n++) begin
            if (!busy1 && !busy4 && m_mode[0] == 0 && m_mode[1] == 0) done = 1;
            else cycle();
        end
        chk("idle_timeout", int'(done), 1);
    endtask

    initial begin
        bit want;
        rst = 1'b1; start = 1'b0; plate = 8'h00;
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Idle after reset: nothing moves.
        for (int k = 0; k < 20; k++) begin
            cycle();
            chk("idle_pos", int'(pos1), 8'h88);
            chk("idle_busy", int'(busy1), 0);
        end

        // First serve, diagonal run into the right edge.
        plate = 8'h00;
        serve();
        chk("serve_pos", int'(pos1), 8'h88);
        chk("serve_dir", int'(dir1), 2'b11);
        for (int k = 1; k <= 7; k++) begin
            cycle();
            chk("diag_pos", int'(pos1), 8'h88 + 8'h11 * k);
        end
        cycle();
        chk("edge_miss", int'(miss1), 1);
        chk("edge_pos", int'(pos1), 8'hFF);
        chk("edge_busy", int'(busy1), 0);
        cycle();
        chk("after_miss_busy", int'(busy1), 0);

        // Second serve goes the other way.
        serve();
        chk("serve2_dir", int'(dir1), 2'b00);
        chk("serve2_hc", int'(hc1), 0);
        cycle();
        chk("serve2_step", int'(pos1), 8'h77);
        wait_idle();

        // Paddle hit at column 12, rows 10-12.
        plate = 8'hCA;
        serve();
        chk("serve3_dir", int'(dir1), 2'b11);
        repeat (3) cycle();
        chk("pre_hit_pos", int'(pos1), 8'hBB);
        cycle();
        chk("hit_pulse", int'(hit1), 1);
        chk("hit_pos", int'(pos1), 8'hBC);
        chk("hit_dir", int'(dir1), 2'b01);
        chk("hit_hc", int'(hc1), 1);
        cycle();
        chk("post_hit_pos", int'(pos1), 8'hAD);
        chk("post_hit_pulse", int'(hit1), 0);
        wait_idle();

        // TICK_DIV=4 cadence, async reset mid-run, toggle cleared by reset.
        #2 rst = 1'b1;
        model_reset();
        cycle();
        rst = 1'b0;
        serve();
        for (int k = 1; k <= 8; k++) begin
            cycle();
            chk("td4_cadence", int'(pos4), (k < 4) ? 8'h88 : (k < 8) ? 8'h99 : 8'hAA);
        end
        cycle();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async_pos", int'(pos4), 8'h88);
        chk("async_busy", int'(busy4), 0);
        chk("async_dir", int'(dir4), 2'b11);
        #1 rst = 1'b0;
        serve();
        chk("serve_after_rst_dir", int'(dir4), 2'b11);

        // Randomised play, biased toward the clipped paddle at rows 14-16.
        for (int it = 0; it < 3000; it++) begin
            start = ($urandom_range(0, 3) == 0);
            if (m_mode[0] == 2 && m_x[0] == 11 && m_dx[0] == 1 && $urandom_range(0, 1) == 1)
                plate = 8'hCE;
            else
                plate = {($urandom_range(0, 1) == 1) ? 4'd12 : 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15))};
            if (plate == 8'hCE && m_mode[0] == 2 && m_x[0] == 11 && m_dx[0] == 1 && m_y[0] >= 13) begin
                want = (m_y[0] >= 14);
                cycle();
                chk("clip_hit", int'(hit1), int'(want));
            end else if ($urandom_range(0, 699) == 0) begin
                #2 rst = 1'b1;
                model_reset();
                #1 chk("rand_rst_busy", int'(busy1 | busy4), 0);
                cycle();
                rst = 1'b0;
            end else begin
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
